bht_btb_predictor: RTL

Parametrised dynamic branch predictor replacing the single-state predictor in the RV32i pipeline. Holds a direct-mapped table of saturating counters plus a tagged branch target buffer. The ID stage looks it up combinationally to steer next-PC; the EXE stage writes resolved outcomes back one or more cycles later. Optional gshare indexing and performance counters expose prediction quality.

---
 rtl/bp_pkg.sv | 35 +++
 rtl/bp_sat_ctr.sv | 34 +++
 rtl/bht_btb_predictor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch predictor.
//   ctr_weak_nt / ctr_weak_t : counter reset / allocation values for a given width
//   btb_entry_t              : one BTB entry {valid, tag, target}
//   pc_idx / pc_tag          : index and tag fields of a PC
// The tag field is sized for the widest legal tag. Narrower configurations
// zero-extend, so the unused upper bits stay constant and are trimmed.
package bp_pkg;

  localparam int MAX_TAG_W = 28;  // IDX_BITS >= 2 and IDX_BITS+TAG_BITS <= 30
  localparam int MAX_CTR_W = 4;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  function automatic logic [MAX_CTR_W-1:0] ctr_weak_t(int unsigned ctr_bits);
    return MAX_CTR_W'(1 << (ctr_bits - 1));
  endfunction

  function automatic logic [MAX_CTR_W-1:0] ctr_weak_nt(int unsigned ctr_bits);
    return MAX_CTR_W'((1 << (ctr_bits - 1)) - 1);
  endfunction

  function automatic logic [31:0] pc_idx(logic [31:0] pc, int unsigned idx_bits);
    return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  function automatic logic [MAX_TAG_W-1:0] pc_tag(logic [31:0] pc, int unsigned idx_bits,
                                                 int unsigned tag_bits);
    return MAX_TAG_W'((pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1));
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr: one W-bit saturating counter.
//   clk, rst_n   : clock, asynchronous active-low reset (to RST_VAL)
//   inc / dec    : saturating step up / down
//   load/load_val: overwrite, takes priority over inc/dec
//   q            : current count
module bp_sat_ctr #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  logic [W-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (load)                    ctr_d = load_val;
    else if (inc && ctr_q != '1) ctr_d = ctr_q + W'(1);
    else if (dec && ctr_q != '0) ctr_d = ctr_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ctr_q <= RST_VAL;
    else        ctr_q <= ctr_d;

  assign q = ctr_q;

endmodule

// File: rtl/bht_btb_predictor.sv
// bht_btb_predictor: direct-mapped saturating-counter BHT plus tagged BTB.
//   clk, rst          : clock, asynchronous active-low reset
//   lu_pc             : ID-stage PC; pred_* are combinational from state
//   pred_hit/taken/target/idx : lookup result, pred_idx is replayed as up_idx
//   up_*              : EXE-stage resolved conditional branch write-back
//   stat_branches/mispred : perf counters (zero when PERF_EN=0)
// Build option: define BP_GSHARE_EN to XOR the lookup index with a global
// history register updated from resolved outcomes.
module bht_btb_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter bit PERF_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         lu_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                up_valid,
  input  logic [IDX_BITS-1:0] up_idx,
  input  logic [31:0]         up_pc,
  input  logic                up_taken,
  input  logic [31:0]         up_target,
  input  logic                up_mispred,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispred
);

  localparam int                ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));

  btb_entry_t [ENTRIES-1:0]               btb_q, btb_d;
  logic       [ENTRIES-1:0][CTR_BITS-1:0] ctr;
  logic       [ENTRIES-1:0]               ctr_inc, ctr_dec, ctr_load;

  logic [IDX_BITS-1:0]  lu_idx;
  logic [MAX_TAG_W-1:0] lu_tag, up_tag;
  btb_entry_t           lu_ent;
  logic                 up_hit;

  // ---------------- lookup ----------------
`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (up_valid) ghr_d = {ghr_q[IDX_BITS-2:0], up_taken};
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;

  assign lu_idx = IDX_BITS'(pc_idx(lu_pc, IDX_BITS)) ^ ghr_q;
`else
  assign lu_idx = IDX_BITS'(pc_idx(lu_pc, IDX_BITS));
`endif

  assign lu_tag      = pc_tag(lu_pc, IDX_BITS, TAG_BITS);
  assign lu_ent      = btb_q[lu_idx];
  assign pred_hit    = lu_ent.valid && (lu_ent.tag == lu_tag);
  assign pred_taken  = pred_hit && ctr[lu_idx][CTR_BITS-1];
  assign pred_target = pred_hit ? lu_ent.target : 32'd0;
  assign pred_idx    = lu_idx;

  // ---------------- update ----------------
  // An invalid entry behaves like a tag miss: taken allocates, not-taken is dropped.
  assign up_tag = pc_tag(up_pc, IDX_BITS, TAG_BITS);
  assign up_hit = btb_q[up_idx].valid && (btb_q[up_idx].tag == up_tag);

  always_comb begin
    btb_d = btb_q;
    if (up_valid && up_taken) btb_d[up_idx] = '{valid: 1'b1, tag: up_tag, target: up_target};
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) btb_q <= '0;
    else      btb_q <= btb_d;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    logic sel;
    assign sel         = up_valid && (up_idx == IDX_BITS'(g));
    assign ctr_inc[g]  = sel && up_hit && up_taken;
    assign ctr_dec[g]  = sel && up_hit && !up_taken;
    assign ctr_load[g] = sel && !up_hit && up_taken;

    bp_sat_ctr #(.W(CTR_BITS), .RST_VAL(WEAK_NT)) u_ctr (
      .clk      (clk),
      .rst_n    (rst),
      .inc      (ctr_inc[g]),
      .dec      (ctr_dec[g]),
      .load     (ctr_load[g]),
      .load_val (WEAK_T),
      .q        (ctr[g])
    );
  end

  // ---------------- perf counters ----------------
  if (PERF_EN) begin : g_perf
    logic [31:0] br_q, br_d, mp_q, mp_d;

    always_comb begin
      br_d = br_q;
      mp_d = mp_q;
      if (up_valid) begin
        br_d = br_q + 32'd1;
        if (up_mispred) mp_d = mp_q + 32'd1;
      end
    end

    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        br_q <= '0;
        mp_q <= '0;
      end else begin
        br_q <= br_d;
        mp_q <= mp_d;
      end

    assign stat_branches = br_q;
    assign stat_mispred  = mp_q;
  end else begin : g_noperf
    assign stat_branches = '0;
    assign stat_mispred  = '0;
  end

endmodule
